jkff_behv: RTL and testbench

//   Behavioural JK flip-flop register, WIDTH bits wide. Each bit is an independent JK cell.
//   Per-bit operations: hold, clear, set or toggle on every rising clock edge.

---
 rtl/jkff_pkg.sv | 20 ++
 rtl/jkff_bit.sv | 29 ++
 rtl/jkff_behv.sv | 24 ++
 tb/tb_jkff_behv.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/jkff_pkg.sv
// Shared types and next-state helper for the behavioural JK flip-flop register.
package jkff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_t;

  // Sum-of-products form keeps X on either control bit confined to the result bit.
  function automatic logic jk_next(jk_op_t op, logic q);
    logic j;
    logic k;
    j = op[1];
    k = op[0];
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jkff_bit.sv
// Single JK cell: one flop with asynchronous active-high reset to a per-bit value.
module jkff_bit
  import jkff_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);

  logic q_q;
  logic q_d;

  assign q_d = jk_next(jk_op_t'({j, k}), q_q);

  // State flop; reset overrides any edge-coincident J/K operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jkff_behv.sv
// WIDTH independent JK cells; Q is taken straight from the cell flops.
module jkff_behv #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jkff_bit u_bit (
      .clk     (clk),
      .reset   (reset),
      .j       (J[gi]),
      .k       (K[gi]),
      .rst_val (RESET_VALUE[gi]),
      .q       (Q[gi])
    );
  end

endmodule

// File: tb/tb_jkff_behv.sv
// Directed bench for jkff_behv: a 1-bit instance for the classic cases, a 4-bit one for mixed ops.
module tb_jkff_behv;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [0:0] j1    = 1'b0;
  logic [0:0] k1    = 1'b0;
  logic [0:0] q1;
  logic [3:0] j4    = 4'b0000;
  logic [3:0] k4    = 4'b0000;
  logic [3:0] q4;

  int tests_run  = 0;
  int tests_fail = 0;

  jkff_behv #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .J     (j1),
    .K     (k1),
    .Q     (q1)
  );

  jkff_behv #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .J     (j4),
    .K     (k4),
    .Q     (q4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs may then change safely.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic jv, input logic kv);
    j1 = jv;
    k1 = kv;
  endtask

  initial begin
    // 1. reset is immediate, then hold keeps 0
    #1 reset = 1'b1;
    #1;
    check_eq("rst_q1", {3'b000, q1}, 4'b0000);
    check_eq("rst_q4", q4, 4'b0000);
    #1 reset = 1'b0;
    drive1(1'b0, 1'b0);
    edge_step();
    check_eq("hold0_a", {3'b000, q1}, 4'b0000);
    edge_step();
    check_eq("hold0_b", {3'b000, q1}, 4'b0000);

    // 2. set then hold
    drive1(1'b1, 1'b0);
    edge_step();
    check_eq("set", {3'b000, q1}, 4'b0001);
    drive1(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check_eq("hold1", {3'b000, q1}, 4'b0001);
    end

    // 3. clear, twice
    drive1(1'b0, 1'b1);
    edge_step();
    check_eq("clr_a", {3'b000, q1}, 4'b0000);
    edge_step();
    check_eq("clr_b", {3'b000, q1}, 4'b0000);

    // 4. toggle sequence 1,0,1,0
    drive1(1'b1, 1'b1);
    edge_step();
    check_eq("tgl_1", {3'b000, q1}, 4'b0001);
    edge_step();
    check_eq("tgl_2", {3'b000, q1}, 4'b0000);
    edge_step();
    check_eq("tgl_3", {3'b000, q1}, 4'b0001);
    edge_step();
    check_eq("tgl_4", {3'b000, q1}, 4'b0000);

    // 5. sweep {J,K}=0..3 from reset -> 0,0,1,0 then toggle once more -> 1
    reset = 1'b1;
    #2 reset = 1'b0;
    drive1(1'b0, 1'b0);
    edge_step();
    check_eq("sweep_00", {3'b000, q1}, 4'b0000);
    drive1(1'b0, 1'b1);
    edge_step();
    check_eq("sweep_01", {3'b000, q1}, 4'b0000);
    drive1(1'b1, 1'b0);
    edge_step();
    check_eq("sweep_10", {3'b000, q1}, 4'b0001);
    drive1(1'b1, 1'b1);
    edge_step();
    check_eq("sweep_11", {3'b000, q1}, 4'b0000);
    edge_step();
    check_eq("sweep_11b", {3'b000, q1}, 4'b0001);

    // 6. async reset between edges, then reset held across an edge
    #1 reset = 1'b1;
    #1;
    check_eq("async_rst", {3'b000, q1}, 4'b0000);
    #1 reset = 1'b0;
    edge_step();
    check_eq("post_rst_tgl", {3'b000, q1}, 4'b0001);
    drive1(1'b1, 1'b0);
    reset = 1'b1;
    edge_step();
    check_eq("rst_over_edge", {3'b000, q1}, 4'b0000);
    reset = 1'b0;
    edge_step();
    check_eq("set_after_rst", {3'b000, q1}, 4'b0001);

    // 7. 4-bit mixed ops: set/clr/toggle/hold per bit
    check_eq("w4_idle", q4, 4'b0000);
    j4 = 4'b1010;
    k4 = 4'b0110;
    edge_step();
    check_eq("w4_mix", q4, 4'b1010);
    j4 = 4'b1111;
    k4 = 4'b1111;
    edge_step();
    check_eq("w4_tgl", q4, 4'b0101);
    j4 = 4'b0011;
    k4 = 4'b0101;
    edge_step();
    check_eq("w4_mix2", q4, 4'b0010);
    j4 = 4'b0000;
    k4 = 4'b0000;
    edge_step();
    check_eq("w4_hold", q4, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
